// File: rtl/calc1_port_sched_if.sv
// Signal bundle between four calc1 requester ports, the port scheduler and the shared ALU.
interface calc1_port_sched_if;
  logic [3:0]  req1_cmd_in,  req2_cmd_in,  req3_cmd_in,  req4_cmd_in;
  logic [31:0] req1_data_in, req2_data_in, req3_data_in, req4_data_in;
  logic [1:0]  out_resp1, out_resp2, out_resp3, out_resp4;
  logic [31:0] out_data1, out_data2, out_data3, out_data4;
  logic        alu_valid;
  logic [3:0]  alu_cmd;
  logic [31:0] alu_op1, alu_op2;
  logic        alu_done;
  logic [1:0]  alu_resp;
  logic [31:0] alu_result;

  modport slave (
    input  req1_cmd_in, req2_cmd_in, req3_cmd_in, req4_cmd_in,
    input  req1_data_in, req2_data_in, req3_data_in, req4_data_in,
    input  alu_done, alu_resp, alu_result,
    output out_resp1, out_resp2, out_resp3, out_resp4,
    output out_data1, out_data2, out_data3, out_data4,
    output alu_valid, alu_cmd, alu_op1, alu_op2
  );

  modport master (
    output req1_cmd_in, req2_cmd_in, req3_cmd_in, req4_cmd_in,
    output req1_data_in, req2_data_in, req3_data_in, req4_data_in,
    output alu_done, alu_resp, alu_result,
    input  out_resp1, out_resp2, out_resp3, out_resp4,
    input  out_data1, out_data2, out_data3, out_data4,
    input  alu_valid, alu_cmd, alu_op1, alu_op2
  );
endinterface

// File: rtl/calc1_port_sched.sv
// Four-port calc1 request front end: buffers two-cycle requests, rejects bad commands
// locally and shares one ALU round-robin with a completion timeout.
module calc1_port_sched #(
  parameter int unsigned TIMEOUT_CYC = 64,
  parameter logic [1:0]  TO_RESP     = 2'b11
) (
  input logic               c_clk,
  input logic               reset,
  calc1_port_sched_if.slave bus
);
  localparam int unsigned   CW      = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {P_IDLE, P_OP2, P_PEND, P_RUN} port_st_e;
  typedef enum logic {A_FREE, A_BUSY} alu_st_e;

  logic [3:0]    w_cmd_in  [4];
  logic [31:0]   w_data_in [4];

  port_st_e      r_pst     [4];
  port_st_e      w_pst_nxt [4];
  logic [3:0]    r_cmd     [4];
  logic [31:0]   r_op1     [4];
  logic [31:0]   r_op2     [4];
  logic [1:0]    r_resp    [4];
  logic [31:0]   r_rdata   [4];

  alu_st_e       r_ast, w_ast_nxt;
  logic [1:0]    r_ptr, r_owner;
  logic [CW-1:0] r_to_cnt;
  logic          r_alu_valid;
  logic [3:0]    r_alu_cmd;
  logic [31:0]   r_alu_op1, r_alu_op2;

  logic [3:0]    w_cand;
  logic [1:0]    w_scan, w_gidx;
  logic          w_grant, w_timeout, w_finish;

  function automatic logic cmd_ok(input logic [3:0] c);
    return (c == 4'd1) || (c == 4'd2) || (c == 4'd5) || (c == 4'd6);
  endfunction

  always_comb begin
    w_cmd_in[0]  = bus.req1_cmd_in;  w_cmd_in[1]  = bus.req2_cmd_in;
    w_cmd_in[2]  = bus.req3_cmd_in;  w_cmd_in[3]  = bus.req4_cmd_in;
    w_data_in[0] = bus.req1_data_in; w_data_in[1] = bus.req2_data_in;
    w_data_in[2] = bus.req3_data_in; w_data_in[3] = bus.req4_data_in;
  end

  // Ports finishing OP2 with a good command already compete for the ALU, so an
  // uncontended request launches two cycles after its command cycle.
  always_comb begin
    w_timeout = (r_ast == A_BUSY) && !bus.alu_done && (r_to_cnt == TO_LAST);
    w_finish  = (r_ast == A_BUSY) && (bus.alu_done || w_timeout);
    for (int unsigned k = 0; k < 4; k++) begin
      w_cand[k] = (r_pst[k] == P_PEND) || ((r_pst[k] == P_OP2) && cmd_ok(r_cmd[k]));
    end
    w_grant = 1'b0;
    w_gidx  = r_ptr;
    w_scan  = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      w_scan = r_ptr + 2'(i);
      if (!w_grant && w_cand[w_scan]) begin
        w_grant = 1'b1;
        w_gidx  = w_scan;
      end
    end
    if (!((r_ast == A_FREE) || w_finish)) w_grant = 1'b0;

    w_ast_nxt = r_ast;
    if (w_finish) w_ast_nxt = A_FREE;
    if (w_grant)  w_ast_nxt = A_BUSY;

    for (int unsigned k = 0; k < 4; k++) begin
      w_pst_nxt[k] = r_pst[k];
      case (r_pst[k])
        P_IDLE:  if (w_cmd_in[k] != '0) w_pst_nxt[k] = P_OP2;
        P_OP2:   w_pst_nxt[k] = cmd_ok(r_cmd[k]) ? P_PEND : P_IDLE;
        P_PEND:  w_pst_nxt[k] = P_PEND;
        P_RUN:   if (w_finish) w_pst_nxt[k] = P_IDLE;
        default: w_pst_nxt[k] = P_IDLE;
      endcase
      if (w_grant && (w_gidx == 2'(k))) w_pst_nxt[k] = P_RUN;
    end
  end

  always_ff @(posedge c_clk) begin
    if (reset) begin
      r_ast       <= A_FREE;
      r_ptr       <= '0;
      r_owner     <= '0;
      r_to_cnt    <= '0;
      r_alu_valid <= 1'b0;
      r_alu_cmd   <= '0;
      r_alu_op1   <= '0;
      r_alu_op2   <= '0;
      for (int unsigned k = 0; k < 4; k++) begin
        r_pst[k]   <= P_IDLE;
        r_cmd[k]   <= '0;
        r_op1[k]   <= '0;
        r_op2[k]   <= '0;
        r_resp[k]  <= '0;
        r_rdata[k] <= '0;
      end
    end else begin
      r_ast       <= w_ast_nxt;
      r_alu_valid <= w_grant;
      for (int unsigned k = 0; k < 4; k++) begin
        r_pst[k]   <= w_pst_nxt[k];
        r_resp[k]  <= '0;
        r_rdata[k] <= '0;
        if ((r_pst[k] == P_IDLE) && (w_cmd_in[k] != '0)) begin
          r_cmd[k] <= w_cmd_in[k];
          r_op1[k] <= w_data_in[k];
        end
        if (r_pst[k] == P_OP2) begin
          r_op2[k] <= w_data_in[k];
          if (!cmd_ok(r_cmd[k])) r_resp[k] <= 2'd2;
        end
      end
      if (w_finish) begin
        if (bus.alu_done) begin
          r_resp[r_owner]  <= bus.alu_resp;
          r_rdata[r_owner] <= (bus.alu_resp == 2'd1) ? bus.alu_result : '0;
        end else begin
          r_resp[r_owner]  <= TO_RESP;
        end
      end
      if (w_grant) begin
        r_alu_cmd <= r_cmd[w_gidx];
        r_alu_op1 <= r_op1[w_gidx];
        r_alu_op2 <= (r_pst[w_gidx] == P_OP2) ? w_data_in[w_gidx] : r_op2[w_gidx];
        r_owner   <= w_gidx;
        r_ptr     <= w_gidx + 2'd1;
      end
      if (w_grant || w_finish) r_to_cnt <= '0;
      else if (r_ast == A_BUSY) r_to_cnt <= r_to_cnt + CW'(1);
    end
  end

  always_comb begin
    bus.out_resp1 = r_resp[0];  bus.out_data1 = r_rdata[0];
    bus.out_resp2 = r_resp[1];  bus.out_data2 = r_rdata[1];
    bus.out_resp3 = r_resp[2];  bus.out_data3 = r_rdata[2];
    bus.out_resp4 = r_resp[3];  bus.out_data4 = r_rdata[3];
    bus.alu_valid = r_alu_valid;
    bus.alu_cmd   = r_alu_cmd;
    bus.alu_op1   = r_alu_op1;
    bus.alu_op2   = r_alu_op2;
  end
endmodule

// File: tb/tb_calc1_port_sched.sv
// Bench for calc1_port_sched: directed vector table, hand-written multi-cycle sequences,
// and random traffic against a transaction-timing reference model.
module tb_calc1_port_sched;
  localparam int         TO_CYC = 64;
  localparam logic [1:0] TO_R   = 2'b11;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  calc1_port_sched_if bus();

  calc1_port_sched #(.TIMEOUT_CYC(TO_CYC), .TO_RESP(TO_R)) dut (
    .c_clk (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          port;
    logic [3:0]  cmd;
    logic [31:0] op1;
    logic [31:0] op2;
    int          lat;
    logic [1:0]  aresp;
    logic [31:0] ares;
    logic [1:0]  exp_resp;
    logic [31:0] exp_data;
    bit          exp_launch;
  } vec_t;

  vec_t vecs[7];

  // reference model state (times are cycle numbers)
  int          m_cap[4];
  logic [3:0]  m_cmd[4];
  logic [31:0] m_op1[4];
  logic [31:0] m_op2[4];
  bit          m_gr[4];
  int          m_ptr, m_own, m_L;
  bit          m_fly;
  bit          e_valid;
  logic [3:0]  e_cmd;
  logic [31:0] e_op1, e_op2;
  logic [1:0]  e_resp[4];
  logic [31:0] e_data[4];

  int          done_cyc;
  logic [1:0]  rsp_r;
  logic [31:0] rsp_y;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic bit cmd_ok(input logic [3:0] c);
    return (c == 4'd1) || (c == 4'd2) || (c == 4'd5) || (c == 4'd6);
  endfunction

  task automatic set_req(input int p, input logic [3:0] c, input logic [31:0] d);
    case (p)
      0: begin bus.req1_cmd_in = c; bus.req1_data_in = d; end
      1: begin bus.req2_cmd_in = c; bus.req2_data_in = d; end
      2: begin bus.req3_cmd_in = c; bus.req3_data_in = d; end
      default: begin bus.req4_cmd_in = c; bus.req4_data_in = d; end
    endcase
  endtask

  function automatic logic [3:0] get_cmd(input int p);
    case (p)
      0: return bus.req1_cmd_in;
      1: return bus.req2_cmd_in;
      2: return bus.req3_cmd_in;
      default: return bus.req4_cmd_in;
    endcase
  endfunction

  function automatic logic [31:0] get_din(input int p);
    case (p)
      0: return bus.req1_data_in;
      1: return bus.req2_data_in;
      2: return bus.req3_data_in;
      default: return bus.req4_data_in;
    endcase
  endfunction

  function automatic logic [1:0] get_resp(input int p);
    case (p)
      0: return bus.out_resp1;
      1: return bus.out_resp2;
      2: return bus.out_resp3;
      default: return bus.out_resp4;
    endcase
  endfunction

  function automatic logic [31:0] get_data(input int p);
    case (p)
      0: return bus.out_data1;
      1: return bus.out_data2;
      2: return bus.out_data3;
      default: return bus.out_data4;
    endcase
  endfunction

  task automatic idle_inputs();
    for (int p = 0; p < 4; p++) set_req(p, 4'd0, 32'd0);
    bus.alu_done   = 1'b0;
    bus.alu_resp   = 2'd0;
    bus.alu_result = 32'd0;
  endtask

  task automatic alu_calc(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                          output logic [1:0] r, output logic [31:0] y);
    logic [32:0] s;
    case (c)
      4'd1: begin s = {1'b0, a} + {1'b0, b}; y = s[31:0]; r = s[32] ? 2'd2 : 2'd1; end
      4'd2: begin y = a - b; r = (a < b) ? 2'd2 : 2'd1; end
      4'd5: begin y = a << b[4:0]; r = 2'd1; end
      4'd6: begin y = a >> b[4:0]; r = 2'd1; end
      default: begin y = a ^ b; r = 2'd2; end
    endcase
  endtask

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      m_cap[k] = -1; m_gr[k] = 0; m_cmd[k] = '0; m_op1[k] = '0; m_op2[k] = '0;
    end
    m_ptr = 0; m_own = 0; m_L = 0; m_fly = 0;
  endtask

  // Predicts outputs of cycle t+1 from model state and the inputs applied in cycle t.
  task automatic model_step(input int t);
    bit was_free[4];
    bit alu_free;
    int k;
    e_valid = 0; e_cmd = '0; e_op1 = '0; e_op2 = '0;
    for (int q = 0; q < 4; q++) begin
      was_free[q] = (m_cap[q] < 0);
      e_resp[q] = '0;
      e_data[q] = '0;
    end
    for (int q = 0; q < 4; q++) begin
      if (m_cap[q] >= 0 && m_cap[q] == t - 1) begin
        m_op2[q] = get_din(q);
        if (!cmd_ok(m_cmd[q])) begin
          e_resp[q] = 2'd2;
          m_cap[q]  = -1;
        end
      end
    end
    alu_free = !m_fly;
    if (m_fly && (bus.alu_done || (t - m_L == TO_CYC - 1))) begin
      if (bus.alu_done) begin
        e_resp[m_own] = bus.alu_resp;
        e_data[m_own] = (bus.alu_resp == 2'd1) ? bus.alu_result : 32'd0;
      end else begin
        e_resp[m_own] = TO_R;
      end
      m_cap[m_own] = -1;
      m_gr[m_own]  = 0;
      m_fly        = 0;
      alu_free     = 1;
    end
    if (alu_free) begin
      for (int i = 0; i < 4; i++) begin
        k = (m_ptr + i) % 4;
        if (!m_fly && m_cap[k] >= 0 && m_cap[k] <= t - 1 && !m_gr[k] && cmd_ok(m_cmd[k])) begin
          e_valid = 1; e_cmd = m_cmd[k]; e_op1 = m_op1[k]; e_op2 = m_op2[k];
          m_gr[k] = 1; m_fly = 1; m_own = k; m_L = t + 1; m_ptr = (k + 1) % 4;
        end
      end
    end
    for (int q = 0; q < 4; q++) begin
      if (was_free[q] && get_cmd(q) != 4'd0) begin
        m_cap[q] = t; m_cmd[q] = get_cmd(q); m_op1[q] = get_din(q); m_gr[q] = 0;
      end
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    set_req(v.port, v.cmd, v.op1);
    tick();
    set_req(v.port, 4'd0, v.op2);
    tick();
    set_req(v.port, 4'd0, 32'd0);
    chk($sformatf("v%0d launch", idx), bus.alu_valid, v.exp_launch);
    if (v.exp_launch) begin
      chk($sformatf("v%0d alu_cmd", idx), bus.alu_cmd, v.cmd);
      chk($sformatf("v%0d alu_op1", idx), bus.alu_op1, v.op1);
      chk($sformatf("v%0d alu_op2", idx), bus.alu_op2, v.op2);
      for (int j = 0; j < v.lat; j++) begin
        tick();
        if (j == 0) chk($sformatf("v%0d strobe once", idx), bus.alu_valid, 0);
      end
      bus.alu_done = 1'b1; bus.alu_resp = v.aresp; bus.alu_result = v.ares;
      tick();
      bus.alu_done = 1'b0;
    end
    chk($sformatf("v%0d resp", idx), get_resp(v.port), v.exp_resp);
    chk($sformatf("v%0d data", idx), get_data(v.port), v.exp_data);
    tick();
    chk($sformatf("v%0d resp clears", idx), get_resp(v.port), 0);
    tick();
    tick();
  endtask

  task automatic all4_round(input int o0, input int o1, input int o2, input int o3,
                            input logic [31:0] base, input string tag);
    int ord[4];
    ord[0] = o0; ord[1] = o1; ord[2] = o2; ord[3] = o3;
    for (int p = 0; p < 4; p++) set_req(p, 4'd1, base * (p + 1));
    tick();
    for (int p = 0; p < 4; p++) set_req(p, 4'd0, p + 1);
    tick();
    for (int p = 0; p < 4; p++) set_req(p, 4'd0, 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s grant%0d valid", tag, i), bus.alu_valid, 1);
      chk($sformatf("%s grant%0d port", tag, i), bus.alu_op1, base * (ord[i] + 1));
      bus.alu_done = 1'b1; bus.alu_resp = 2'd1; bus.alu_result = 32'hC000 + i;
      tick();
      bus.alu_done = 1'b0;
      chk($sformatf("%s resp%0d", tag, i), get_resp(ord[i]), 1);
      chk($sformatf("%s data%0d", tag, i), get_data(ord[i]), 32'hC000 + i);
    end
    chk($sformatf("%s drained", tag), bus.alu_valid, 0);
    tick();
  endtask

  initial begin
    int cnt;
    logic [3:0] c;
    n_checks = 0;
    n_errors = 0;
    done_cyc = -1;
    vecs[0] = '{0, 4'd1, 32'h1, 32'h1FFF_FFFF, 3, 2'd1, 32'h2000_0000, 2'd1, 32'h2000_0000, 1'b1};
    vecs[1] = '{1, 4'd3, 32'h12, 32'h34, 0, 2'd0, 32'h0, 2'd2, 32'h0, 1'b0};
    vecs[2] = '{1, 4'd4, 32'h56, 32'h78, 0, 2'd0, 32'h0, 2'd2, 32'h0, 1'b0};
    vecs[3] = '{0, 4'd2, 32'h1, 32'hF, 1, 2'd2, 32'hFFFF_FFF2, 2'd2, 32'h0, 1'b1};
    vecs[4] = '{2, 4'd5, 32'h3, 32'h4, 0, 2'd1, 32'h30, 2'd1, 32'h30, 1'b1};
    vecs[5] = '{3, 4'd15, 32'h9, 32'h9, 0, 2'd0, 32'h0, 2'd2, 32'h0, 1'b0};
    vecs[6] = '{3, 4'd6, 32'h80, 32'h3, 2, 2'd1, 32'h10, 2'd1, 32'h10, 1'b1};

    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    chk("reset alu_valid", bus.alu_valid, 0);
    chk("reset alu_cmd", bus.alu_cmd, 0);
    chk("reset alu_op1", bus.alu_op1, 0);
    chk("reset alu_op2", bus.alu_op2, 0);
    for (int p = 0; p < 4; p++) begin
      chk($sformatf("reset resp%0d", p + 1), get_resp(p), 0);
      chk($sformatf("reset data%0d", p + 1), get_data(p), 0);
    end

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // contention: pointer sits at port 1 after the table
    all4_round(0, 1, 2, 3, 32'h100, "rr1");
    set_req(2, 4'd1, 32'h333);
    tick();
    set_req(2, 4'd0, 32'h1);
    tick();
    set_req(2, 4'd0, 32'h0);
    chk("rr solo valid", bus.alu_valid, 1);
    chk("rr solo op1", bus.alu_op1, 32'h333);
    bus.alu_done = 1'b1; bus.alu_resp = 2'd1; bus.alu_result = 32'h334;
    tick();
    bus.alu_done = 1'b0;
    chk("rr solo resp", get_resp(2), 1);
    tick();
    all4_round(3, 0, 1, 2, 32'h200, "rr2");

    // timeout on port 1 with port 2 waiting, then a late done while free
    set_req(0, 4'd1, 32'hA);
    set_req(1, 4'd1, 32'hB);
    tick();
    set_req(0, 4'd0, 32'h1);
    set_req(1, 4'd0, 32'h2);
    tick();
    idle_inputs();
    chk("to launch", bus.alu_valid, 1);
    chk("to launch op1", bus.alu_op1, 32'hA);
    for (int i = 1; i <= TO_CYC - 1; i++) tick();
    chk("to early resp", get_resp(0), 0);
    tick();
    chk("to resp", get_resp(0), TO_R);
    chk("to data", get_data(0), 0);
    chk("to next grant", bus.alu_valid, 1);
    chk("to next op1", bus.alu_op1, 32'hB);
    bus.alu_done = 1'b1; bus.alu_resp = 2'd1; bus.alu_result = 32'h55;
    tick();
    bus.alu_done = 1'b0;
    chk("to port2 resp", get_resp(1), 1);
    chk("to port2 data", get_data(1), 32'h55);
    tick();
    bus.alu_done = 1'b1; bus.alu_resp = 2'd1; bus.alu_result = 32'h77;
    tick();
    bus.alu_done = 1'b0;
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      for (int p = 0; p < 4; p++) if (get_resp(p) != 2'd0) cnt++;
      if (bus.alu_valid) cnt++;
      tick();
    end
    chk("late done ignored", cnt, 0);

    // busy drop: extra commands during OP2 and while in flight are discarded
    set_req(0, 4'd1, 32'h5);
    tick();
    set_req(0, 4'd2, 32'h6);
    tick();
    set_req(0, 4'd6, 32'h0);
    chk("drop launch", bus.alu_valid, 1);
    chk("drop op2", bus.alu_op2, 32'h6);
    tick();
    set_req(0, 4'd0, 32'h0);
    bus.alu_done = 1'b1; bus.alu_resp = 2'd1; bus.alu_result = 32'hB;
    tick();
    bus.alu_done = 1'b0;
    chk("drop resp", get_resp(0), 1);
    chk("drop data", get_data(0), 32'hB);
    tick();
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (get_resp(0) != 2'd0 || bus.alu_valid) cnt++;
      tick();
    end
    chk("drop single resp", cnt, 0);

    // reset while busy, then a stray done
    set_req(2, 4'd1, 32'h44);
    tick();
    set_req(2, 4'd0, 32'h4);
    tick();
    set_req(2, 4'd0, 32'h0);
    chk("rst launch", bus.alu_valid, 1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst alu_op1", bus.alu_op1, 0);
    cnt = 0;
    for (int p = 0; p < 4; p++) if (get_resp(p) != 2'd0 || get_data(p) != 32'd0) cnt++;
    chk("rst outputs", cnt, 0);
    tick();
    bus.alu_done = 1'b1; bus.alu_resp = 2'd1; bus.alu_result = 32'h99;
    tick();
    bus.alu_done = 1'b0;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      for (int p = 0; p < 4; p++) if (get_resp(p) != 2'd0) cnt++;
      if (bus.alu_valid) cnt++;
      tick();
    end
    chk("rst no responses", cnt, 0);

    // random traffic against the reference model
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_reset();
    done_cyc = -1;
    for (int t = 0; t < 3000; t++) begin
      if (bus.alu_valid) begin
        if ($urandom_range(0, 9) == 0) done_cyc = -1;
        else done_cyc = t + int'($urandom_range(0, 6));
        alu_calc(bus.alu_cmd, bus.alu_op1, bus.alu_op2, rsp_r, rsp_y);
      end
      for (int p = 0; p < 4; p++) begin
        case ($urandom_range(0, 15))
          11: c = 4'd1;
          12: c = 4'd2;
          13: c = 4'd5;
          14: c = 4'd6;
          15: c = ($urandom_range(0, 1) == 1) ? 4'd3 : 4'($urandom_range(7, 15));
          default: c = 4'd0;
        endcase
        set_req(p, c, $urandom());
      end
      bus.alu_done   = (t == done_cyc);
      bus.alu_resp   = bus.alu_done ? rsp_r : 2'($urandom());
      bus.alu_result = bus.alu_done ? rsp_y : $urandom();
      model_step(t);
      tick();
      chk($sformatf("rnd%0d alu_valid", t), bus.alu_valid, e_valid);
      if (e_valid) begin
        chk($sformatf("rnd%0d alu_cmd", t), bus.alu_cmd, e_cmd);
        chk($sformatf("rnd%0d alu_op1", t), bus.alu_op1, e_op1);
        chk($sformatf("rnd%0d alu_op2", t), bus.alu_op2, e_op2);
      end
      for (int p = 0; p < 4; p++) begin
        chk($sformatf("rnd%0d resp%0d", t, p + 1), get_resp(p), e_resp[p]);
        chk($sformatf("rnd%0d data%0d", t, p + 1), get_data(p), e_data[p]);
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
